// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg: shared widths, FSM state encoding and last-grant encoding for the buffer scheduler
// Ports: none (package only).
package mem_sched_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DEPTH      = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT_WR,
        ST_GRANT_RD,
        ST_RD_CAPTURE
    } state_e;

    // Which requester received the most recent grant; drives tie-breaking.
    typedef enum logic {
        LG_WR,
        LG_RD
    } last_grant_e;

endpackage

// File: rtl/mem_sched_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin picker with a registered last-grant record
// Ports: clk_i/rst_ni clock and async active-low reset; en_i allows a decision this cycle;
//   req_i {rd, wr} eligibility; gnt_o {rd, wr} one-hot choice (zero when disabled or idle).
module rr_arbiter2
    import mem_sched_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    last_grant_e last_q;

    // A lone requester passes straight through; a tie goes to whoever did not win last time.
    always_comb gnt_o = !en_i ? 2'b00 : (&req_i) ? (last_q == LG_RD ? 2'b01 : 2'b10) : req_i;

    // Reset to RD so the writer wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            last_q <= LG_RD;
        else if (|gnt_o)
            last_q <= gnt_o[0] ? LG_WR : LG_RD;
    end

endmodule

// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler: FIFO-style scheduler sharing one single-port word buffer between a writer and a reader
// Ports: clk_i/rst_ni clock and async active-low reset;
//   wr_req_i/wr_data_i/wr_grant_o writer handshake (one word per grant);
//   rd_req_i/rd_grant_o/rd_data_o/rd_valid_o reader handshake (data two cycles after grant);
//   mem_addr_o/mem_we_o/mem_re_o/mem_wdata_o/mem_rdata_i buffer interface (synchronous read);
//   full_o/empty_o/count_o occupancy flags and word count.
module mem_port_scheduler
    import mem_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_req_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_grant_o,
    input  logic                  rd_req_i,
    output logic                  rd_grant_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic                  mem_re_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH:0]   count_o
);

    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q, mem_addr_q;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, mem_wdata_q;
    logic                  wr_grant_q, rd_grant_q, rd_valid_q, mem_we_q, mem_re_q, full_q, empty_q;
    logic [1:0]            elig, choice;

    always_comb elig = {rd_req_i && !empty_q, wr_req_i && !full_q};

    rr_arbiter2 u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (state_q == ST_IDLE),
        .req_i  (elig),
        .gnt_o  (choice)
    );

    // Occupancy moves only at the end of a grant cycle, so the following IDLE sees fresh flags.
    always_comb count_d = state_q == ST_GRANT_WR ? count_q + 1'b1 :
                          state_q == ST_GRANT_RD ? count_q - 1'b1 : count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            wr_grant_q  <= 1'b0;
            rd_grant_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
        end else begin
            wr_grant_q <= 1'b0;
            rd_grant_q <= 1'b0;
            rd_valid_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            count_q    <= count_d;
            full_q     <= count_d == CNT_FULL;
            empty_q    <= count_d == '0;
            case (state_q)
                ST_IDLE: begin
                    if (choice[0]) begin
                        state_q     <= ST_GRANT_WR;
                        wr_grant_q  <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= wr_ptr_q;
                        mem_wdata_q <= wr_data_i;
                    end else if (choice[1]) begin
                        state_q    <= ST_GRANT_RD;
                        rd_grant_q <= 1'b1;
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= rd_ptr_q;
                    end
                end
                ST_GRANT_WR: begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    state_q  <= ST_IDLE;
                end
                ST_GRANT_RD: begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    state_q  <= ST_RD_CAPTURE;
                end
                default: begin
                    // Buffer data arrives the cycle after the read strobe.
                    rd_data_q  <= mem_rdata_i;
                    rd_valid_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_grant_o  = wr_grant_q;
    assign rd_grant_o  = rd_grant_q;
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_re_o    = mem_re_q;
    assign mem_wdata_o = mem_wdata_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign count_o     = count_q;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// tb_mem_port_scheduler: directed stimulus with a queue-based FIFO model checked every cycle
module tb_mem_port_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_req = 1'b0, rd_req = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_grant_o, rd_grant_o, rd_valid_o, mem_we_o, mem_re_o, full_o, empty_o;
    logic [15:0] rd_data_o, mem_wdata_o;
    logic [15:0] mem_rdata = '0;
    logic [3:0]  mem_addr_o;
    logic [4:0]  count_o;
    logic [15:0] mem [16];

    int n_cmp = 0, n_bad = 0;

    mem_port_scheduler dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_n),
        .wr_req_i    (wr_req),
        .wr_data_i   (wr_data),
        .wr_grant_o  (wr_grant_o),
        .rd_req_i    (rd_req),
        .rd_grant_o  (rd_grant_o),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_re_o    (mem_re_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous single-port buffer standing in for the memory instance.
    always @(posedge clk_i) begin
        if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
        if (mem_re_o) mem_rdata <= mem[mem_addr_o];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    // Inputs as the DUT sampled them on the most recent rising edge.
    logic [15:0] wd_prev = '0;
    logic        wreq_prev = 1'b0, rreq_prev = 1'b0;
    initial forever begin
        @(posedge clk_i);
        wd_prev   = wr_data;
        wreq_prev = wr_req;
        rreq_prev = rd_req;
    end

    // FIFO model: a queue of stored words, an occupancy count and the two buffer indices.
    logic [15:0] q[$];
    logic [15:0] exp_rd = '0;
    int mcount = 0, widx = 0, ridx = 0, rd_due = 0;
    initial forever begin
        @(negedge clk_i);
        if (!rst_n) begin
            chk("rst_flags", {wr_grant_o, rd_grant_o, rd_valid_o, mem_we_o, mem_re_o, full_o, empty_o}, 7'b0000001);
            chk("rst_count", count_o, 0);
            chk("rst_addr", mem_addr_o, 0);
            chk("rst_rdata", rd_data_o, 0);
            chk("rst_wdata", mem_wdata_o, 0);
            q.delete();
            mcount = 0; widx = 0; ridx = 0; rd_due = 0;
        end else begin
            chk("count", count_o, mcount);
            chk("full", full_o, mcount == 16);
            chk("empty", empty_o, mcount == 0);
            chk("we_strobe", mem_we_o, wr_grant_o);
            chk("re_strobe", mem_re_o, rd_grant_o);
            chk("one_grant", wr_grant_o & rd_grant_o, 0);
            chk("rd_valid", rd_valid_o, rd_due == 1);
            if (rd_due == 1) chk("rd_data", rd_data_o, exp_rd);
            if (rd_due > 0) rd_due--;
            if (wr_grant_o) begin
                chk("wr_req_seen", wreq_prev, 1);
                chk("wr_not_full", mcount < 16, 1);
                chk("wr_addr", mem_addr_o, widx);
                chk("wr_data", mem_wdata_o, wd_prev);
                q.push_back(wd_prev);
                widx = (widx + 1) % 16;
                mcount++;
            end
            if (rd_grant_o) begin
                chk("rd_req_seen", rreq_prev, 1);
                chk("rd_not_empty", mcount > 0, 1);
                chk("rd_addr", mem_addr_o, ridx);
                exp_rd = q.size() > 0 ? q.pop_front() : 16'hxxxx;
                rd_due = 2;
                ridx = (ridx + 1) % 16;
                mcount--;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic do_write(input logic [15:0] d, output logic [3:0] a, output int lat);
        wr_data = d;
        wr_req = 1'b1;
        a = '0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (wr_grant_o) begin
                a = mem_addr_o;
                lat = i + 1;
                break;
            end
        end
        chk("wr_grant_seen", wr_grant_o, 1);
        wr_req = 1'b0;
    endtask

    task automatic do_read(output logic [15:0] d, output int lat);
        rd_req = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rd_grant_o) begin
                lat = i + 1;
                break;
            end
        end
        chk("rd_grant_seen", rd_grant_o, 1);
        rd_req = 1'b0;
        step();
        step();
        chk("rd_valid_at_3", rd_valid_o, 1);
        d = rd_data_o;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [3:0]  a;
        logic [15:0] d;
        int          lat, n, seen;
        int          seq [8];

        // Reset values, then idle with no requests.
        #1 rst_n = 1'b0;
        step();
        step();
        chk("t1_empty_in_rst", empty_o, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("t1_count", count_o, 0);
        chk("t1_empty", empty_o, 1);
        chk("t1_full", full_o, 0);
        chk("t1_grants", {wr_grant_o, rd_grant_o, rd_valid_o}, 0);

        // Single write then read.
        do_write(16'h0001, a, lat);
        chk("t2_wr_lat", lat, 1);
        chk("t2_wr_addr", a, 0);
        chk("t2_we", mem_we_o, 1);
        step();
        chk("t2_count1", count_o, 1);
        do_read(d, lat);
        chk("t2_rd_lat", lat, 1);
        chk("t2_rdata", d, 16'h0001);
        chk("t2_count0", count_o, 0);
        chk("t2_empty", empty_o, 1);

        // Fill to full, hold a 17th write off, then free one slot.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_write(16'(i + 1), a, lat);
            chk("t3_fill_addr", a, i);
        end
        step();
        chk("t3_count16", count_o, 16);
        chk("t3_full", full_o, 1);
        wr_data = 16'h0011;
        wr_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (wr_grant_o) seen++;
        end
        chk("t3_full_holdoff", seen, 0);
        do_read(d, lat);
        chk("t3_first_out", d, 16'h0001);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (wr_grant_o) begin
                seen = 1;
                break;
            end
        end
        chk("t3_17th_granted", seen, 1);
        chk("t3_17th_addr", mem_addr_o, 0);
        wr_req = 1'b0;
        step();
        chk("t3_full_again", full_o, 1);

        // Contention at Count=4 with the reader granted last, so the writer goes first.
        do_reset();
        for (int i = 0; i < 5; i++) do_write(16'(16'h0020 + i), a, lat);
        do_read(d, lat);
        chk("t4_pre_data", d, 16'h0020);
        chk("t4_count4", count_o, 4);
        wr_data = 16'h0030;
        wr_req = 1'b1;
        rd_req = 1'b1;
        n = 0;
        for (int t = 0; t < 100 && n < 8; t++) begin
            step();
            if (wr_grant_o) begin
                seq[n] = 0;
                n++;
                wr_data = wr_data + 16'd1;
            end else if (rd_grant_o) begin
                seq[n] = 1;
                n++;
            end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        chk("t4_grant_count", n, 8);
        for (int i = 0; i < 8; i++) chk("t4_alternate", seq[i], i % 2);
        step();
        step();
        step();
        chk("t4_count_end", count_o, 4);

        // Wrap-around through many write/read pairs.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            do_write(16'(16'h0100 + i), a, lat);
            chk("t5_wr_addr", a, i % 16);
            do_read(d, lat);
            chk("t5_rdata", d, 16'(16'h0100 + i));
            chk("t5_count_le1", count_o <= 1, 1);
        end

        // Reset during RD_CAPTURE discards the pending read.
        do_reset();
        do_write(16'hAAAA, a, lat);
        rd_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rd_grant_o) break;
        end
        chk("t6_rd_grant", rd_grant_o, 1);
        rd_req = 1'b0;
        step();
        rst_n = 1'b0;
        seen = 0;
        step();
        if (rd_valid_o) seen = 1;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rd_valid_o) seen = 1;
        end
        chk("t6_no_valid", seen, 0);
        chk("t6_count0", count_o, 0);
        chk("t6_empty", empty_o, 1);
        do_write(16'h5555, a, lat);
        chk("t6_addr0", a, 0);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
